seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. It replaces the single-digit combinational BCD decoder at the board display port: it latches a packed BCD word, scans the digits at a fixed refresh rate, and drives active-low anodes and cathodes. It sits between the generation/population counters and the board pins. New values are applied only at frame boundaries, so the display never tears mid-scan.

---
 rtl/seg7_scan_driver.sv | 198 +++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg7_scan_driver                                                |
// | Purpose  : Time-multiplexed N-digit common-anode 7-segment driver with     |
// |            frame-synchronous double-buffered BCD/DP/blank data.            |
// | Option   : SEG7_LEADING_ZERO_BLANK_EN enables leading-zero suppression.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] bcd_in_i,
  input  logic [NUM_DIGITS-1:0]   dp_in_i,
  input  logic [NUM_DIGITS-1:0]   blank_in_i,
  output logic [NUM_DIGITS-1:0]   anode_o,
  output logic [7:0]              cathode_o,
  output logic                    frame_start_o
);

  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNTW = $clog2(REFRESH_DIV);
  localparam logic [CNTW-1:0] c_CNT_LAST = CNTW'(REFRESH_DIV - 1);
  localparam logic [IDXW-1:0] c_IDX_LAST = IDXW'(NUM_DIGITS - 1);

  // run_q holds the scan for one edge after reset release so that the
  // first registered slot appears on the second rising edge.
  logic                    run_q;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [4*NUM_DIGITS-1:0] act_bcd_q, act_bcd_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]              cathode_q, cathode_d;
  logic                    frame_start_q, frame_start_d;

  logic                    w_terminal;
  logic                    w_boundary;
  logic                    w_guard;
  logic                    w_dark;
  logic [3:0]              w_digit;
  logic [4*NUM_DIGITS-1:0] w_src_bcd;
  logic [NUM_DIGITS-1:0]   w_src_dp;
  logic [NUM_DIGITS-1:0]   w_src_blank;

  function automatic logic [7:0] f_seg(input logic [3:0] v);
    case (v)
      4'd0:    f_seg = 8'hC0;
      4'd1:    f_seg = 8'hF9;
      4'd2:    f_seg = 8'hA4;
      4'd3:    f_seg = 8'hB0;
      4'd4:    f_seg = 8'h99;
      4'd5:    f_seg = 8'h92;
      4'd6:    f_seg = 8'h82;
      4'd7:    f_seg = 8'hF8;
      4'd8:    f_seg = 8'h80;
      4'd9:    f_seg = 8'h90;
      default: f_seg = 8'hBF;
    endcase
  endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Blank zero digits from the top down until a non-zero or DP digit; digit 0 always kept.
  function automatic logic [NUM_DIGITS-1:0] f_lead_zero(
    input logic [4*NUM_DIGITS-1:0] bcd,
    input logic [NUM_DIGITS-1:0]   dp
  );
    logic still;
    f_lead_zero = '0;
    still       = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (still && (bcd[4*i +: 4] == 4'd0) && !dp[i]) begin
        f_lead_zero[i] = 1'b1;
      end else begin
        still = 1'b0;
      end
    end
  endfunction
`endif

  generate
    if (GUARD == 0) begin : g_no_guard
      assign w_guard = 1'b0;
    end else begin : g_guard
      assign w_guard = (cnt_q < CNTW'(GUARD));
    end
  endgenerate

  always_comb begin
    w_terminal = run_q && (cnt_q == c_CNT_LAST);
    w_boundary = w_terminal && (idx_q == c_IDX_LAST);
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    if (run_q) begin
      if (w_terminal) begin
        cnt_d = '0;
        idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + IDXW'(1);
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  // A load on the boundary bypasses the pending set and lands in active directly.
  always_comb begin
    w_src_bcd = load_i ? bcd_in_i : pend_bcd_q;
    w_src_dp  = load_i ? dp_in_i  : pend_dp_q;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    w_src_blank = (load_i ? blank_in_i : pend_blank_q) | f_lead_zero(w_src_bcd, w_src_dp);
`else
    w_src_blank = load_i ? blank_in_i : pend_blank_q;
`endif
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_bcd_d   = pend_bcd_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    act_bcd_d    = act_bcd_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    if (load_i && w_boundary) begin
      act_bcd_d    = w_src_bcd;
      act_dp_d     = w_src_dp;
      act_blank_d  = w_src_blank;
      pend_valid_d = 1'b0;
    end else if (load_i) begin
      pend_bcd_d   = bcd_in_i;
      pend_dp_d    = dp_in_i;
      pend_blank_d = blank_in_i;
      pend_valid_d = 1'b1;
    end else if (w_boundary && pend_valid_q) begin
      act_bcd_d    = w_src_bcd;
      act_dp_d     = w_src_dp;
      act_blank_d  = w_src_blank;
      pend_valid_d = 1'b0;
    end
  end

  always_comb begin
    w_digit       = act_bcd_q[{idx_q, 2'b00} +: 4];
    w_dark        = !run_q || w_guard || act_blank_q[idx_q];
    cathode_d     = w_dark ? 8'hFF : (f_seg(w_digit) & {~act_dp_q[idx_q], 7'h7F});
    frame_start_d = run_q && (cnt_q == '0) && (idx_q == '0);
    anode_d       = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anode_d[i] = w_dark || (idx_q != IDXW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      cnt_q         <= '0;
      idx_q         <= '0;
      pend_valid_q  <= 1'b0;
      pend_bcd_q    <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '0;
      act_bcd_q     <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      anode_q       <= '1;
      cathode_q     <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pend_valid_q  <= pend_valid_d;
      pend_bcd_q    <= pend_bcd_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      act_bcd_q     <= act_bcd_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      anode_q       <= anode_d;
      cathode_q     <= cathode_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign anode_o       = anode_q;
  assign cathode_o     = cathode_q;
  assign frame_start_o = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// Testbench for seg7_scan_driver (4 digits, 8-cycle slots, 2 guard cycles):
// scoreboard of per-cycle expected anode/cathode/frame_start.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int GD    = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic [3:0]  anode;
  logic [7:0]  cathode;
  logic        fs;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] ca;
    logic       fs;
  } exp_t;
  exp_t sb[$];

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (load),
    .bcd_in_i      (bcd),
    .dp_in_i       (dp),
    .blank_in_i    (blank),
    .anode_o       (anode),
    .cathode_o     (cathode),
    .frame_start_o (fs)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] tb_seg(input logic [3:0] v);
    case (v)
      4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
      4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
      4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  task automatic push_frame(input logic [15:0] b, input logic [3:0] d, input logic [3:0] bl);
    exp_t e;
    for (int s = 0; s < ND; s++) begin
      for (int c = 0; c < RD; c++) begin
        if (c < GD || bl[s]) begin
          e.an = 4'hF;
          e.ca = 8'hFF;
        end else begin
          e.an = ~(4'b0001 << s);
          e.ca = tb_seg(b[4*s +: 4]) & (d[s] ? 8'h7F : 8'hFF);
        end
        e.fs = (s == 0 && c == 0);
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (fs === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({anode, cathode, fs} !== {4'hF, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL reset_first_edge: anode=%b cathode=%h fs=%b, want 1111 ff 0", anode, cathode, fs);
    end
    @(posedge clk); #1;
    checks++;
    if (fs !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_slot: fs=%b, want 1 on second edge", fs);
    end
    @(negedge clk);
    push_frame(16'h0, 4'h0, 4'hF);
    push_frame(16'h0, 4'h0, 4'hF);
    for (int k = 0; k < 2 * FRAME; k++) begin
      e = sb.pop_front();
      checks++;
      if ({anode, cathode, fs} !== {e.an, e.ca, e.fs}) begin
        errors++;
        $display("FAIL reset_dark cyc=%0d: anode=%b cathode=%h fs=%b, want %b %h %b",
                 k, anode, cathode, fs, e.an, e.ca, e.fs);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_decode();
    exp_t e;
    bit   ok;
    bcd = 16'h1234; dp = 4'h0; blank = 4'h0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL decode_wait: frame_start=0, want a pulse within %0d cycles", 2 * FRAME);
    end
    push_frame(16'h1234, 4'h0, 4'h0);
    for (int k = 0; k < FRAME; k++) begin
      e = sb.pop_front();
      checks++;
      if ({anode, cathode, fs} !== {e.an, e.ca, e.fs}) begin
        errors++;
        $display("FAIL decode cyc=%0d: anode=%b cathode=%h fs=%b, want %b %h %b",
                 k, anode, cathode, fs, e.an, e.ca, e.fs);
      end
      @(negedge clk);
    end
  endtask

  // Two loads in a frame (latest wins), then a load one cycle after the boundary.
  task automatic test_back_to_back();
    exp_t e;
    bit   ok;
    bcd = 16'h1111; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    bcd = 16'h2222; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fs(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_wait: frame_start=0, want a pulse within %0d cycles", 2 * FRAME);
    end
    push_frame(16'h2222, 4'h0, 4'h0);
    push_frame(16'h2222, 4'h0, 4'h0);
    push_frame(16'h5678, 4'h0, 4'h0);
    for (int k = 0; k < 3 * FRAME; k++) begin
      e = sb.pop_front();
      checks++;
      if ({anode, cathode, fs} !== {e.an, e.ca, e.fs}) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d: anode=%b cathode=%h fs=%b, want %b %h %b",
                 k, anode, cathode, fs, e.an, e.ca, e.fs);
      end
      if (k == FRAME - 1) begin
        bcd  = 16'h5678;
        load = 1'b1;
      end
      if (k == FRAME) load = 1'b0;
      @(negedge clk);
    end
  endtask

  // Load presented exactly in the internal boundary cycle.
  task automatic test_boundary_load();
    exp_t       e;
    logic [3:0] exp_bl;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    exp_bl = 4'b1110;
`else
    exp_bl = 4'b0000;
`endif
    push_frame(16'h5678, 4'h0, 4'h0);
    push_frame(16'h0009, 4'b0001, exp_bl);
    for (int k = 0; k < 2 * FRAME; k++) begin
      e = sb.pop_front();
      checks++;
      if ({anode, cathode, fs} !== {e.an, e.ca, e.fs}) begin
        errors++;
        $display("FAIL boundary_load cyc=%0d: anode=%b cathode=%h fs=%b, want %b %h %b",
                 k, anode, cathode, fs, e.an, e.ca, e.fs);
      end
      if (k == FRAME - 2) begin
        bcd = 16'h0009; dp = 4'b0001; blank = 4'h0; load = 1'b1;
      end
      if (k == FRAME - 1) load = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_dash_blank();
    exp_t       e;
    logic [3:0] prev_bl;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    prev_bl = 4'b1110;
`else
    prev_bl = 4'b0000;
`endif
    push_frame(16'h0009, 4'b0001, prev_bl);
    push_frame(16'h7A51, 4'b0010, 4'b1000);
    for (int k = 0; k < 2 * FRAME; k++) begin
      e = sb.pop_front();
      checks++;
      if ({anode, cathode, fs} !== {e.an, e.ca, e.fs}) begin
        errors++;
        $display("FAIL dash_blank cyc=%0d: anode=%b cathode=%h fs=%b, want %b %h %b",
                 k, anode, cathode, fs, e.an, e.ca, e.fs);
      end
      if (k == 5) begin
        bcd = 16'h7A51; dp = 4'b0010; blank = 4'b1000; load = 1'b1;
      end
      if (k == 6) load = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midscan();
    exp_t e;
    repeat (20) @(negedge clk);
    checks++;
    if ({anode, cathode} !== {4'b1011, 8'hBF}) begin
      errors++;
      $display("FAIL pre_reset_slot2: anode=%b cathode=%h, want 1011 bf", anode, cathode);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({anode, cathode, fs} !== {4'hF, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: anode=%b cathode=%h fs=%b, want 1111 ff 0", anode, cathode, fs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({anode, fs} !== {4'hF, 1'b0}) begin
      errors++;
      $display("FAIL rerun_first_edge: anode=%b fs=%b, want 1111 0", anode, fs);
    end
    @(posedge clk); #1;
    checks++;
    if (fs !== 1'b1) begin
      errors++;
      $display("FAIL rerun_slot0: fs=%b, want 1", fs);
    end
    @(negedge clk);
    push_frame(16'h0, 4'h0, 4'hF);
    for (int k = 0; k < FRAME; k++) begin
      e = sb.pop_front();
      checks++;
      if ({anode, cathode, fs} !== {e.an, e.ca, e.fs}) begin
        errors++;
        $display("FAIL rerun_dark cyc=%0d: anode=%b cathode=%h fs=%b, want %b %h %b",
                 k, anode, cathode, fs, e.an, e.ca, e.fs);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_boundary_load();
    test_dash_blank();
    test_reset_midscan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
